// File: rtl/csr_regfile_if.sv
// CSR access bundle: combinational read port and the WB write port.
// The pipeline side is master; the register file is slave.
interface csr_regfile_if;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;

  modport master (
    output csr_rnum,
    output csr_we,
    output csr_wnum,
    output csr_wmask,
    output csr_wvalue,
    input  csr_rvalue
  );

  modport slave (
    input  csr_rnum,
    input  csr_we,
    input  csr_wnum,
    input  csr_wmask,
    input  csr_wvalue,
    output csr_rvalue
  );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch CSR register file: masked writes, exception/ERTN updates,
// constant timer and interrupt request generation.
module csr_regfile #(
  parameter logic [31:0] COREID = 32'd0
) (
  input  logic         clk,
  input  logic         reset,
  csr_regfile_if.slave csr,
  input  logic         wb_ex,
  input  logic [5:0]   wb_ecode,
  input  logic [8:0]   wb_esubcode,
  input  logic [31:0]  wb_pc,
  input  logic         ertn_flush,
  input  logic [7:0]   hw_int_in,
  input  logic         ipi_int_in,
  output logic [31:0]  ex_entry,
  output logic [31:0]  ertn_pc,
  output logic         has_int
);
  localparam logic [13:0] CRMD   = 14'h00;
  localparam logic [13:0] PRMD   = 14'h01;
  localparam logic [13:0] ECFG   = 14'h04;
  localparam logic [13:0] ESTAT  = 14'h05;
  localparam logic [13:0] ERA    = 14'h06;
  localparam logic [13:0] EENTRY = 14'h0c;
  localparam logic [13:0] SAVE0  = 14'h30;
  localparam logic [13:0] SAVE1  = 14'h31;
  localparam logic [13:0] SAVE2  = 14'h32;
  localparam logic [13:0] SAVE3  = 14'h33;
  localparam logic [13:0] TID    = 14'h40;
  localparam logic [13:0] TCFG   = 14'h41;
  localparam logic [13:0] TVAL   = 14'h42;
  localparam logic [13:0] TICLR  = 14'h44;

  logic [1:0]  plv, pplv;
  logic        ie, da, pie;
  logic [12:0] lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ti, is_ipi;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era;
  logic [25:0] eentry_va;
  logic [31:0] save [4];
  logic [31:0] tid;
  logic        tcfg_en, tcfg_per;
  logic [29:0] tcfg_init;
  logic [31:0] tval;

  logic [12:0] is_v;
  logic [31:0] wold, wnew;
  logic        sw_we, tcfg_load, t_tick, t_fire, ticlr;

  assign is_v = {is_ipi, is_ti, 1'b0, is_hw, is_sw};

  function automatic logic [31:0] rd_mux(input logic [13:0] n);
    logic [31:0] r;
    r = 32'd0;
    case (n)
      CRMD:   r = {28'd0, da, ie, plv};
      PRMD:   r = {29'd0, pie, pplv};
      ECFG:   r = {19'd0, lie};
      ESTAT:  r = {1'b0, esubcode, ecode, 3'd0, is_v};
      ERA:    r = era;
      EENTRY: r = {eentry_va, 6'd0};
      SAVE0:  r = save[0];
      SAVE1:  r = save[1];
      SAVE2:  r = save[2];
      SAVE3:  r = save[3];
      TID:    r = tid;
      TCFG:   r = {tcfg_init, tcfg_per, tcfg_en};
      TVAL:   r = tval;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_comb csr.csr_rvalue = rd_mux(csr.csr_rnum);
  always_comb wold = rd_mux(csr.csr_wnum);

  assign wnew = (wold & ~csr.csr_wmask)
              | (csr.csr_wvalue & csr.csr_wmask);

  // Exception and ERTN commits shadow a same-cycle CSR write.
  assign sw_we     = csr.csr_we & ~wb_ex & ~ertn_flush;
  assign tcfg_load = sw_we && csr.csr_wnum == TCFG && wnew[0];
  assign t_tick    = tcfg_en && tval != 32'd0;
  assign t_fire    = tcfg_en && tval == 32'd1;
  assign ticlr     = sw_we && csr.csr_wnum == TICLR
                   && csr.csr_wvalue[0] && csr.csr_wmask[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      {da, ie, plv} <= 4'h8;
      {pie, pplv}   <= 3'd0;
      lie           <= '0;
      is_sw         <= '0;
      is_hw         <= '0;
      is_ti         <= 1'b0;
      is_ipi        <= 1'b0;
      ecode         <= '0;
      esubcode      <= '0;
      era           <= '0;
      eentry_va     <= '0;
      save[0]       <= '0;
      save[1]       <= '0;
      save[2]       <= '0;
      save[3]       <= '0;
      tid           <= COREID;
      tcfg_en       <= 1'b0;
      tcfg_per      <= 1'b0;
      tcfg_init     <= '0;
      tval          <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (t_fire) is_ti <= 1'b1;
      else if (ticlr) is_ti <= 1'b0;
      if (tcfg_load) tval <= {wnew[31:2], 2'b00};
      else if (t_fire) tval <= tcfg_per ? {tcfg_init, 2'b00} : 32'd0;
      else if (t_tick) tval <= tval - 32'd1;
      if (wb_ex) begin
        pplv     <= plv;
        pie      <= ie;
        plv      <= 2'd0;
        ie       <= 1'b0;
        era      <= wb_pc;
        ecode    <= wb_ecode;
        esubcode <= wb_esubcode;
      end else if (ertn_flush) begin
        plv <= pplv;
        ie  <= pie;
      end else if (csr.csr_we) begin
        case (csr.csr_wnum)
          CRMD:   {da, ie, plv} <= wnew[3:0];
          PRMD:   {pie, pplv} <= wnew[2:0];
          ECFG:   lie <= wnew[12:0];
          ESTAT:  is_sw <= wnew[1:0];
          ERA:    era <= wnew;
          EENTRY: eentry_va <= wnew[31:6];
          SAVE0, SAVE1, SAVE2, SAVE3:
            save[csr.csr_wnum[1:0]] <= wnew;
          TID:    tid <= wnew;
          TCFG:   {tcfg_init, tcfg_per, tcfg_en} <= wnew;
          default: ;
        endcase
      end
    end
  end

  assign has_int  = (|(is_v & lie)) & ie;
  assign ex_entry = {eentry_va, 6'd0};
  assign ertn_pc  = era;
endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed vectors with literal checks plus a
// word-level CSR model compared against the outputs every cycle.
module tb_csr_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_ex, ertn_flush, ipi_int_in;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [7:0]  hw_int_in;
  logic [31:0] ex_entry, ertn_pc;
  logic        has_int;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  csr_regfile_if bus();

  csr_regfile #(.COREID(32'd5)) dut (
    .clk(clk),
    .reset(reset),
    .csr(bus),
    .wb_ex(wb_ex),
    .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc),
    .ertn_flush(ertn_flush),
    .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in),
    .ex_entry(ex_entry),
    .ertn_pc(ertn_pc),
    .has_int(has_int)
  );

  always #5 clk = ~clk;

  // Model: one 32-bit word per CSR number, updated by the architectural rules.
  logic [31:0] mreg [0:127];

  function automatic logic [31:0] wr_bits(input logic [13:0] n);
    case (n)
      14'h00: return 32'h0000_000f;
      14'h01: return 32'h0000_0007;
      14'h04: return 32'h0000_1fff;
      14'h05: return 32'h0000_0003;
      14'h06, 14'h30, 14'h31, 14'h32, 14'h33,
      14'h40, 14'h41: return 32'hffff_ffff;
      14'h0c: return 32'hffff_ffc0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [13:0] n);
    if (wr_bits(n) != 32'h0 || n == 14'h42) return mreg[n[6:0]];
    return 32'h0;
  endfunction

  function automatic logic m_int();
    return (|(mreg[5][12:0] & mreg[4][12:0])) & mreg[0][2];
  endfunction

  initial for (int i = 0; i < 128; i++) mreg[i] = 32'h0;

  always @(posedge clk) begin
    logic [31:0] nx [0:127];
    logic [31:0] tc, tv, m;
    logic fire;
    for (int i = 0; i < 128; i++) nx[i] = mreg[i];
    if (reset) begin
      for (int i = 0; i < 128; i++) nx[i] = 32'h0;
      nx[7'h00] = 32'h8;
      nx[7'h40] = 32'd5;
    end else begin
      tc = mreg[7'h41];
      tv = mreg[7'h42];
      fire = tc[0] && tv == 32'd1;
      if (tc[0] && tv != 32'd0)
        nx[7'h42] = (tv == 32'd1) ? (tc[1] ? {tc[31:2], 2'b00} : 32'd0)
                                  : tv - 32'd1;
      nx[7'h05][9:2] = hw_int_in;
      nx[7'h05][12]  = ipi_int_in;
      if (wb_ex) begin
        nx[7'h01][2:0]   = mreg[7'h00][2:0];
        nx[7'h00][2:0]   = 3'd0;
        nx[7'h06]        = wb_pc;
        nx[7'h05][21:16] = wb_ecode;
        nx[7'h05][30:22] = wb_esubcode;
      end else if (ertn_flush) begin
        nx[7'h00][2:0] = mreg[7'h01][2:0];
      end else if (bus.csr_we) begin
        if (bus.csr_wnum == 14'h44) begin
          if (bus.csr_wvalue[0] & bus.csr_wmask[0]) nx[7'h05][11] = 1'b0;
        end else if (wr_bits(bus.csr_wnum) != 32'h0) begin
          m = bus.csr_wmask & wr_bits(bus.csr_wnum);
          nx[bus.csr_wnum[6:0]] = (nx[bus.csr_wnum[6:0]] & ~m)
                                | (bus.csr_wvalue & m);
          if (bus.csr_wnum == 14'h41 && nx[7'h41][0])
            nx[7'h42] = {nx[7'h41][31:2], 2'b00};
        end
      end
      if (fire) nx[7'h05][11] = 1'b1;
    end
    for (int i = 0; i < 128; i++) mreg[i] = nx[i];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rvalue", bus.csr_rvalue, m_rd(bus.csr_rnum));
      chk("model_has_int", {31'd0, has_int}, {31'd0, m_int()});
      chk("model_ex_entry", ex_entry, mreg[7'h0c]);
      chk("model_ertn_pc", ertn_pc, mreg[7'h06]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] v,
                    input logic [31:0] m);
    bus.csr_we = 1'b1;
    bus.csr_wnum = n;
    bus.csr_wvalue = v;
    bus.csr_wmask = m;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] v);
    bus.csr_rnum = n;
    #1;
    v = bus.csr_rvalue;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1;
    wb_ex = 1'b0;
    ertn_flush = 1'b0;
    wb_ecode = '0;
    wb_esubcode = '0;
    wb_pc = '0;
    hw_int_in = '0;
    ipi_int_in = 1'b0;
    bus.csr_rnum = '0;
    bus.csr_we = 1'b0;
    bus.csr_wnum = '0;
    bus.csr_wvalue = '0;
    bus.csr_wmask = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;

    rd(14'h00, v); chk("reset_crmd", v, 32'h8);
    rd(14'h40, v); chk("reset_tid", v, 32'd5);
    rd(14'h05, v); chk("reset_estat", v, 32'h0);
    chk("reset_has_int", {31'd0, has_int}, 32'd0);

    wr(14'h00, 32'h5, 32'h7);
    rd(14'h00, v); chk("masked_write", v, 32'hd);
    wr(14'h00, 32'hffff_ffff, 32'h0);
    rd(14'h00, v); chk("zero_mask", v, 32'hd);

    wr(14'h00, 32'h7, 32'h7);
    wb_ex = 1'b1; wb_ecode = 6'hb; wb_esubcode = 9'h0;
    wb_pc = 32'h1c00_0100;
    tick();
    wb_ex = 1'b0;
    rd(14'h00, v); chk("ex_crmd", v, 32'h8);
    rd(14'h01, v); chk("ex_prmd", v, 32'h7);
    rd(14'h06, v); chk("ex_era", v, 32'h1c00_0100);
    rd(14'h05, v); chk("ex_ecode", {26'd0, v[21:16]}, 32'hb);
    chk("ertn_pc", ertn_pc, 32'h1c00_0100);
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    rd(14'h00, v); chk("ertn_crmd", v, 32'hf);

    wr(14'h0c, 32'h1c00_8044, 32'hffff_ffff);
    chk("ex_entry", ex_entry, 32'h1c00_8040);
    wr(14'h02, 32'hffff_ffff, 32'hffff_ffff);
    rd(14'h02, v); chk("unimpl_reads_0", v, 32'h0);
    rd(14'h44, v); chk("ticlr_reads_0", v, 32'h0);

    wr(14'h41, 32'h9, 32'hffff_ffff);
    rd(14'h42, v); chk("oneshot_load", v, 32'd8);
    for (int i = 1; i < 8; i++) begin
      tick();
      rd(14'h42, v); chk("oneshot_count", v, 32'(8 - i));
    end
    tick();
    rd(14'h42, v); chk("oneshot_zero", v, 32'd0);
    rd(14'h05, v); chk("oneshot_is11", {31'd0, v[11]}, 32'd1);
    repeat (3) tick();
    rd(14'h42, v); chk("oneshot_hold", v, 32'd0);
    rd(14'h05, v); chk("oneshot_is11_hold", {31'd0, v[11]}, 32'd1);
    wr(14'h44, 32'h1, 32'h1);
    rd(14'h05, v); chk("ticlr_clears", {31'd0, v[11]}, 32'd0);

    wr(14'h04, 32'h800, 32'hffff_ffff);
    wr(14'h00, 32'h4, 32'h4);
    wr(14'h41, 32'hb, 32'hffff_ffff);
    repeat (7) tick();
    chk("periodic_before", {31'd0, has_int}, 32'd0);
    tick();
    chk("periodic_fire1", {31'd0, has_int}, 32'd1);
    wr(14'h44, 32'h1, 32'h1);
    chk("periodic_cleared", {31'd0, has_int}, 32'd0);
    repeat (6) tick();
    chk("periodic_gap", {31'd0, has_int}, 32'd0);
    rd(14'h42, v); chk("periodic_tval1", v, 32'd1);
    wr(14'h44, 32'h1, 32'h1);
    chk("race_ticlr_fire", {31'd0, has_int}, 32'd1);
    rd(14'h42, v); chk("periodic_reload", v, 32'd8);
    wr(14'h41, 32'h0, 32'hffff_ffff);
    wr(14'h44, 32'h1, 32'h1);

    wr(14'h30, 32'h1234_5678, 32'hffff_ffff);
    wb_ex = 1'b1; wb_ecode = 6'h1; wb_esubcode = 9'h1a5;
    wb_pc = 32'h1c00_0200;
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h30;
    bus.csr_wvalue = 32'hdead_beef; bus.csr_wmask = 32'hffff_ffff;
    tick();
    wb_ex = 1'b0; bus.csr_we = 1'b0;
    rd(14'h30, v); chk("race_ex_save0", v, 32'h1234_5678);
    rd(14'h05, v); chk("ex_esubcode", {23'd0, v[30:22]}, 32'h1a5);
    ertn_flush = 1'b1;
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h31;
    tick();
    ertn_flush = 1'b0; bus.csr_we = 1'b0;
    rd(14'h31, v); chk("race_ertn_save1", v, 32'h0);

    hw_int_in = 8'ha5; ipi_int_in = 1'b1;
    tick();
    hw_int_in = 8'h0; ipi_int_in = 1'b0;
    rd(14'h05, v); chk("is_hw_ipi", {19'd0, v[12:0]}, 32'h1294);
    tick();
    wr(14'h05, 32'hffff_ffff, 32'hffff_ffff);
    rd(14'h05, v); chk("is_sw_only", {19'd0, v[12:0]}, 32'h3);

    wr(14'h04, 32'h1fff, 32'hffff_ffff);
    wr(14'h00, 32'h4, 32'h4);
    chk("sw_int", {31'd0, has_int}, 32'd1);
    wr(14'h41, 32'h41, 32'hffff_ffff);
    tick();
    rd(14'h42, v); chk("midcount_tval", v, 32'h3f);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(14'h42, v); chk("rst_tval", v, 32'h0);
    rd(14'h41, v); chk("rst_tcfg", v, 32'h0);
    rd(14'h05, v); chk("rst_estat", v, 32'h0);
    rd(14'h00, v); chk("rst_crmd", v, 32'h8);
    chk("rst_has_int", {31'd0, has_int}, 32'd0);
    repeat (3) tick();
    rd(14'h42, v); chk("rst_tval_stays", v, 32'h0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
